// File: rtl/n_bit_sqrt.sv
// rtl/n_bit_sqrt.sv - sequential restoring square root, one root bit per clock
module n_bit_sqrt #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] radicand,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   root,
  output logic [N:0]     remainder
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  // Working registers: radicand shifter, partial root, partial remainder, pair counter.
  // The partial remainder is N+2 bits: before the final step it fits in N bits,
  // so shifting in one more bit pair never overflows.
  logic [2*N-1:0] shreg;
  logic [N-1:0]   proot;
  logic [N+1:0]   prem;
  logic [CW-1:0]  cnt;

  logic [N+1:0]   rem_sh;
  logic [N+1:0]   trial;
  logic [N+1:0]   rem_nx;
  logic [N-1:0]   root_nx;
  logic           ge;
  logic           last;

  // One restoring step: bring down the next bit pair and try subtracting 4*root+1
  always_comb begin
    rem_sh  = (prem << 2) | (N+2)'(shreg[2*N-1 -: 2]);
    trial   = {proot, 2'b01};
    ge      = (rem_sh >= trial);
    rem_nx  = ge ? (rem_sh - trial) : rem_sh;
    root_nx = proot << 1;
    root_nx[0] = ge;
    last    = (cnt == '0);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)         state_nx = CALC;
      CALC:    if (last)             state_nx = DONE;
      DONE:    if (out_ready)        state_nx = IDLE;
      default:                       state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from registered state only
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath: capture operand, iterate, and latch the result on the last pair
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      proot     <= '0;
      prem      <= '0;
      cnt       <= '0;
      root      <= '0;
      remainder <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shreg <= radicand;
            proot <= '0;
            prem  <= '0;
            cnt   <= CW'(N - 1);
          end
        end
        CALC: begin
          shreg <= shreg << 2;
          prem  <= rem_nx;
          proot <= root_nx;
          if (last) begin
            root      <= root_nx;
            remainder <= rem_nx[N:0];
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
